// File: rtl/pio_access_arbiter_if.sv
// pio_access_arbiter_if: requester handshakes and the shared PIO slave bus, as seen by the arbiter.
interface pio_access_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              rq0_req;
    logic              rq0_write;
    logic [ADDR_W-1:0] rq0_address;
    logic [DATA_W-1:0] rq0_writedata;
    logic              rq0_ack;
    logic [DATA_W-1:0] rq0_readdata;
    logic              rq1_req;
    logic              rq1_write;
    logic [ADDR_W-1:0] rq1_address;
    logic [DATA_W-1:0] rq1_writedata;
    logic              rq1_ack;
    logic [DATA_W-1:0] rq1_readdata;
    logic [ADDR_W-1:0] pio_address;
    logic              pio_chipselect;
    logic              pio_write_n;
    logic [DATA_W-1:0] pio_writedata;
    logic [DATA_W-1:0] pio_readdata;
    logic              busy;

    modport slave (
        input  rq0_req, rq0_write, rq0_address, rq0_writedata,
        input  rq1_req, rq1_write, rq1_address, rq1_writedata,
        input  pio_readdata,
        output rq0_ack, rq0_readdata, rq1_ack, rq1_readdata,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata, busy
    );

    modport master (
        output rq0_req, rq0_write, rq0_address, rq0_writedata,
        output rq1_req, rq1_write, rq1_address, rq1_writedata,
        output pio_readdata,
        input  rq0_ack, rq0_readdata, rq1_ack, rq1_readdata,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata, busy
    );
endinterface

// File: rtl/pio_access_arbiter.sv
// pio_access_arbiter: round-robin sharing of one Avalon-MM PIO slave between two req/ack requesters,
// one transaction in flight, IDLE -> ISSUE -> DONE with every output registered.
module pio_access_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    pio_access_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic              busy_q, busy_d;
    logic              start, pick, issue;

    always_comb begin
        issue   = state_q == ISSUE;
        start   = state_q == IDLE && (bus.rq0_req || bus.rq1_req);
        // Under contention the requester that did not win last time gets the slot.
        pick    = (bus.rq0_req && bus.rq1_req) ? ~last_q : bus.rq1_req;
        state_d = start ? ISSUE : issue ? DONE : IDLE;
        gnt_d   = start ? pick : gnt_q;
        wr_d    = start ? (pick ? bus.rq1_write : bus.rq0_write) : wr_q;
        addr_d  = start ? (pick ? bus.rq1_address : bus.rq0_address) : addr_q;
        wdata_d = start ? (pick ? bus.rq1_writedata : bus.rq0_writedata) : wdata_q;
        cs_d    = start;
        wn_d    = start ? ~wr_d : 1'b1;
        ack0_d  = issue && !gnt_q;
        ack1_d  = issue && gnt_q;
        rd0_d   = (issue && !wr_q && !gnt_q) ? bus.pio_readdata : rd0_q;
        rd1_d   = (issue && !wr_q && gnt_q) ? bus.pio_readdata : rd1_q;
        last_d  = state_q == DONE ? gnt_q : last_q;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.pio_address    = addr_q;
    assign bus.pio_writedata  = wdata_q;
    assign bus.pio_chipselect = cs_q;
    assign bus.pio_write_n    = wn_q;
    assign bus.rq0_ack        = ack0_q;
    assign bus.rq1_ack        = ack1_q;
    assign bus.rq0_readdata   = rd0_q;
    assign bus.rq1_readdata   = rd1_q;
    assign bus.busy           = busy_q;
endmodule
